// File: rtl/idma_mchan_pkg.sv
// Shared types for the multi-channel 64-bit iDMA register frontend:
// channel state encoding, per-channel config snapshot and backend burst request.
package idma_mchan_pkg;

    localparam int unsigned PkgAddrWidth = 64;
    localparam int unsigned AxiIdWidth   = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        PEND   = 2'b01,
        ISSUED = 2'b10
    } chan_state_t;

    typedef struct packed {
        logic [3:0] cache;
        logic       decouple;
        logic       deburst;
        logic       pv;
    } chan_opt_t;

    typedef struct packed {
        logic [PkgAddrWidth-1:0] src;
        logic [PkgAddrWidth-1:0] dst;
        logic [PkgAddrWidth-1:0] num_bytes;
        logic [PkgAddrWidth-1:0] stride;
        chan_opt_t               opt;
    } chan_cfg_t;

    typedef struct packed {
        logic [AxiIdWidth-1:0] axi_id;
        logic [3:0]            cache;
        logic                  decouple;
        logic                  deburst;
        logic                  pv;
    } burst_opt_t;

    typedef struct packed {
        logic [PkgAddrWidth-1:0] length;
        logic [PkgAddrWidth-1:0] src_addr;
        logic [PkgAddrWidth-1:0] dst_addr;
        burst_opt_t              opt;
    } mchan_burst_req_t;

endpackage

// File: rtl/idma_mchan_chan_ctrl.sv
// One DMA channel: launch/config snapshot, strided burst offset, remaining
// count and next/done transfer-ID counters.
//   state  | meaning
//   IDLE   | no transfer; launch accepted when num_bytes != 0
//   PEND   | a burst is ready and waiting for arbitration
//   ISSUED | burst handed to the backend, waiting for trans_complete
module idma_mchan_chan_ctrl
    import idma_mchan_pkg::*;
#(
    parameter int unsigned CountWidth = 32,
    parameter int unsigned IdWidth    = 32
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    launch_i,
    input  chan_cfg_t               cfg_i,
    input  logic [CountWidth-1:0]   n_trans_i,
    input  logic                    grant_i,
    input  logic                    complete_i,
    input  logic                    abort_i,
    output logic                    launch_ack_o,
    output logic [IdWidth-1:0]      next_id_o,
    output logic [IdWidth-1:0]      done_id_o,
    output logic                    busy_o,
    output logic                    pend_o,
    output logic                    issued_o,
    output logic [PkgAddrWidth-1:0] src_o,
    output logic [PkgAddrWidth-1:0] dst_o,
    output chan_cfg_t               cfg_o
);

    chan_state_t             state_q, state_d;
    chan_cfg_t               cfg_q, cfg_d;
    logic [CountWidth-1:0]   remaining_q, remaining_d;
    logic [PkgAddrWidth-1:0] offset_q, offset_d;
    logic [IdWidth-1:0]      issued_q, issued_d;
    logic [IdWidth-1:0]      done_q, done_d;
    logic                    abort_q, abort_d;

    assign launch_ack_o = (state_q == IDLE) && launch_i && (cfg_i.num_bytes != '0);

    always_comb begin
        state_d     = state_q;
        cfg_d       = cfg_q;
        remaining_d = remaining_q;
        offset_d    = offset_q;
        issued_d    = issued_q;
        done_d      = done_q;
        abort_d     = abort_q;
        unique case (state_q)
            IDLE: begin
                if (launch_ack_o) begin
                    state_d     = PEND;
                    cfg_d       = cfg_i;
                    issued_d    = issued_q + IdWidth'(1);
                    remaining_d = (n_trans_i == '0) ? CountWidth'(1) : n_trans_i;
                    offset_d    = '0;
                    abort_d     = 1'b0;
                end
            end
            PEND: begin
                // A burst granted in the same cycle as an abort is already gone;
                // let it finish and retire the channel at its completion.
                if (grant_i) begin
                    state_d     = ISSUED;
                    remaining_d = remaining_q - CountWidth'(1);
                    offset_d    = offset_q + cfg_q.stride;
                    abort_d     = abort_i;
                end else if (abort_i) begin
                    state_d = IDLE;
                    done_d  = done_q + IdWidth'(1);
                end
            end
            ISSUED: begin
                if (abort_i) abort_d = 1'b1;
                if (complete_i) begin
                    if (abort_q || abort_i || (remaining_q == '0)) begin
                        state_d = IDLE;
                        done_d  = done_q + IdWidth'(1);
                        abort_d = 1'b0;
                    end else begin
                        state_d = PEND;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            cfg_q       <= '0;
            remaining_q <= '0;
            offset_q    <= '0;
            issued_q    <= '0;
            done_q      <= '0;
            abort_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cfg_q       <= cfg_d;
            remaining_q <= remaining_d;
            offset_q    <= offset_d;
            issued_q    <= issued_d;
            done_q      <= done_d;
            abort_q     <= abort_d;
        end
    end

    assign next_id_o = launch_ack_o ? (issued_q + IdWidth'(1)) : '0;
    assign done_id_o = done_q;
    assign busy_o    = (state_q != IDLE);
    assign pend_o    = (state_q == PEND);
    assign issued_o  = (state_q == ISSUED);
    assign src_o     = cfg_q.src + offset_q;
    assign dst_o     = cfg_q.dst + offset_q;
    assign cfg_o     = cfg_q;

endmodule

// File: rtl/idma_reg64_mchan_frontend.sv
// Multi-channel register frontend: per-channel controllers, round-robin
// arbiter and burst mux onto one backend. IDMA_MCHAN_ABORT_EN adds abort_i.
module idma_reg64_mchan_frontend
    import idma_mchan_pkg::*;
#(
    parameter int unsigned NumChannels = 4,
    parameter int unsigned AddrWidth   = PkgAddrWidth,
    parameter int unsigned CountWidth  = 32,
    parameter int unsigned IdWidth     = 32,
    parameter type         burst_req_t = mchan_burst_req_t,
    parameter logic [AxiIdWidth-1:0] AxID = '0,
    localparam int unsigned ChanW = (NumChannels > 1) ? $clog2(NumChannels) : 1
) (
    input  logic                                   clk_i,
    input  logic                                   rst_ni,
    input  logic [NumChannels-1:0]                 launch_i,
    input  logic [NumChannels-1:0][AddrWidth-1:0]  src_addr_i,
    input  logic [NumChannels-1:0][AddrWidth-1:0]  dst_addr_i,
    input  logic [NumChannels-1:0][AddrWidth-1:0]  num_bytes_i,
    input  logic [NumChannels-1:0][AddrWidth-1:0]  stride_i,
    input  logic [NumChannels-1:0][CountWidth-1:0] n_trans_i,
    input  chan_opt_t [NumChannels-1:0]            opt_i,
`ifdef IDMA_MCHAN_ABORT_EN
    input  logic [NumChannels-1:0]                 abort_i,
`endif
    output logic [NumChannels-1:0]                 launch_ack_o,
    output logic [NumChannels-1:0][IdWidth-1:0]    next_id_o,
    output logic [NumChannels-1:0][IdWidth-1:0]    done_id_o,
    output logic [NumChannels-1:0]                 busy_o,
    output burst_req_t                             burst_req_o,
    output logic [ChanW-1:0]                       burst_chan_o,
    output logic                                   valid_o,
    input  logic                                   ready_i,
    input  logic                                   trans_complete_i
);

    logic [NumChannels-1:0]  pend, issued, grant, abort;
    logic [PkgAddrWidth-1:0] ch_src [NumChannels];
    logic [PkgAddrWidth-1:0] ch_dst [NumChannels];
    chan_cfg_t               ch_cfg [NumChannels];

    logic [ChanW-1:0] ptr_q, ptr_d, lock_chan_q, win;
    logic             lock_q, found, outstanding;
    int unsigned      k;

`ifdef IDMA_MCHAN_ABORT_EN
    assign abort = abort_i;
`else
    assign abort = '0;
`endif

    for (genvar c = 0; c < NumChannels; c++) begin : g_chan
        chan_cfg_t cfg_in;
        assign cfg_in   = '{src: src_addr_i[c], dst: dst_addr_i[c], num_bytes: num_bytes_i[c],
                            stride: stride_i[c], opt: opt_i[c]};
        assign grant[c] = valid_o && ready_i && (win == ChanW'(c));

        idma_mchan_chan_ctrl #(
            .CountWidth(CountWidth),
            .IdWidth   (IdWidth)
        ) u_chan (
            .clk_i       (clk_i),
            .rst_ni      (rst_ni),
            .launch_i    (launch_i[c]),
            .cfg_i       (cfg_in),
            .n_trans_i   (n_trans_i[c]),
            .grant_i     (grant[c]),
            .complete_i  (trans_complete_i),
            .abort_i     (abort[c]),
            .launch_ack_o(launch_ack_o[c]),
            .next_id_o   (next_id_o[c]),
            .done_id_o   (done_id_o[c]),
            .busy_o      (busy_o[c]),
            .pend_o      (pend[c]),
            .issued_o    (issued[c]),
            .src_o       (ch_src[c]),
            .dst_o       (ch_dst[c]),
            .cfg_o       (ch_cfg[c])
        );
    end

    // trans_complete_i is untagged, so only one burst may be in flight.
    assign outstanding = |issued;

    // A winner left waiting on ready_i is locked so a later launch cannot overtake it.
    always_comb begin
        found = 1'b0;
        win   = ptr_q;
        k     = 0;
        if (lock_q && pend[lock_chan_q]) begin
            found = 1'b1;
            win   = lock_chan_q;
        end else begin
            for (int unsigned i = 0; i < NumChannels; i++) begin
                k = 32'(ptr_q) + i;
                if (k >= NumChannels) k = k - NumChannels;
                if (!found && pend[ChanW'(k)]) begin
                    found = 1'b1;
                    win   = ChanW'(k);
                end
            end
        end
    end

    assign valid_o = found && !outstanding;

    always_comb begin
        ptr_d = ptr_q;
        if (valid_o && ready_i)
            ptr_d = (win == ChanW'(NumChannels - 1)) ? '0 : win + ChanW'(1);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            ptr_q       <= '0;
            lock_q      <= 1'b0;
            lock_chan_q <= '0;
        end else begin
            ptr_q       <= ptr_d;
            lock_q      <= valid_o && !ready_i;
            lock_chan_q <= win;
        end
    end

    always_comb begin
        burst_req_o  = '0;
        burst_chan_o = '0;
        if (valid_o) begin
            burst_chan_o            = win;
            burst_req_o.length      = ch_cfg[win].num_bytes;
            burst_req_o.src_addr    = ch_src[win];
            burst_req_o.dst_addr    = ch_dst[win];
            burst_req_o.opt.axi_id  = AxID;
            burst_req_o.opt.cache   = ch_cfg[win].opt.cache;
            burst_req_o.opt.decouple = ch_cfg[win].opt.decouple;
            burst_req_o.opt.deburst = ch_cfg[win].opt.deburst;
            burst_req_o.opt.pv      = ch_cfg[win].opt.pv;
        end
    end

endmodule

// File: tb/tb_idma_reg64_mchan_frontend.sv
// Directed bench for idma_reg64_mchan_frontend: table of single-channel transfers
// plus hand-written multi-channel, stall, reset and (optional) abort sequences.
module tb_idma_reg64_mchan_frontend;
    import idma_mchan_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [3:0] launch = '0;
    logic [3:0][63:0] src_a = '0, dst_a = '0, nb_a = '0, str_a = '0;
    logic [3:0][31:0] nt_a = '0;
    chan_opt_t [3:0] opt_a = '0;
    logic [3:0] ack, busy;
    logic [3:0][31:0] next_id, done_id;
    mchan_burst_req_t breq;
    logic [1:0] bchan;
    logic valid;
    logic ready = 1'b0;
    logic tcomp = 1'b0;
`ifdef IDMA_MCHAN_ABORT_EN
    logic [3:0] abort = '0;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    idma_reg64_mchan_frontend dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .launch_i        (launch),
        .src_addr_i      (src_a),
        .dst_addr_i      (dst_a),
        .num_bytes_i     (nb_a),
        .stride_i        (str_a),
        .n_trans_i       (nt_a),
        .opt_i           (opt_a),
`ifdef IDMA_MCHAN_ABORT_EN
        .abort_i         (abort),
`endif
        .launch_ack_o    (ack),
        .next_id_o       (next_id),
        .done_id_o       (done_id),
        .busy_o          (busy),
        .burst_req_o     (breq),
        .burst_chan_o    (bchan),
        .valid_o         (valid),
        .ready_i         (ready),
        .trans_complete_i(tcomp)
    );

    typedef struct {
        int          ch;
        logic [63:0] src, dst, nb, stride;
        logic [31:0] nt;
        int          bursts;
        logic [63:0] last_src;
        logic [31:0] id;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic set_cfg(int ch, logic [63:0] s, d, nb, st, logic [31:0] nt);
        src_a[ch] = s; dst_a[ch] = d; nb_a[ch] = nb; str_a[ch] = st; nt_a[ch] = nt;
        opt_a[ch] = chan_opt_t'(7'h2A + ch);
    endtask

    // All tasks start and end 1 time unit after a falling edge.
    task automatic launch_ch(int ch, logic [63:0] s, d, nb, st, logic [31:0] nt,
                             logic exp_ack, logic [31:0] exp_id);
        set_cfg(ch, s, d, nb, st, nt);
        launch[ch] = 1'b1;
        #1;
        chk("launch_ack", ack[ch], exp_ack);
        chk("next_id", next_id[ch], exp_id);
        @(negedge clk);
        launch = '0;
        #1;
    endtask

    task automatic wait_valid(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            if (valid) ok = 1'b1;
            else begin
                @(negedge clk);
                #1;
            end
        end
        chk("valid_timeout", ok, 1);
    endtask

    task automatic take_burst(int ch, logic [63:0] s, d, len, output logic [63:0] got_src);
        bit ok;
        wait_valid(ok);
        got_src = breq.src_addr;
        chk("burst_chan", bchan, ch);
        chk("burst_src", breq.src_addr, s);
        chk("burst_dst", breq.dst_addr, d);
        chk("burst_len", breq.length, len);
        chk("burst_cache", breq.opt.cache, opt_a[ch].cache);
        ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
        #1;
        chk("valid_while_outstanding", valid, 0);
        tcomp = 1'b1;
        @(negedge clk);
        tcomp = 1'b0;
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(negedge clk);
        #1;
        chk("rst_valid", valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ack", ack, 0);
        chk("rst_next_id", next_id[1], 0);
        chk("rst_done_id0", done_id[0], 0);
        chk("rst_done_id1", done_id[1], 0);
        chk("rst_burst_src", breq.src_addr, 0);
        chk("rst_burst_chan", bchan, 0);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        logic [63:0] got, s, d;
        logic [63:0] held_src;
        bit ok;
        int exp_ch[6];

        vecs[0] = '{0, 64'h8000_0000, 64'h9000_0000, 64'h40, 64'h1000, 32'd3, 3, 64'h8000_2000, 32'd1};
        vecs[1] = '{1, 64'hFFFF_FFFF_FFFF_F000, 64'h10, 64'h8, 64'h800, 32'd3, 3, 64'h0, 32'd1};
        vecs[2] = '{2, 64'h100, 64'h200, 64'h1, 64'h0, 32'd0, 1, 64'h100, 32'd1};
        vecs[3] = '{0, 64'h40, 64'h80, 64'h20, 64'h20, 32'd2, 2, 64'h60, 32'd2};
        vecs[4] = '{3, 64'h1234_5678_0000_0000, 64'h0, 64'hFFFF, 64'h10, 32'd1, 1, 64'h1234_5678_0000_0000, 32'd1};
        exp_ch = '{0, 1, 2, 0, 1, 2};

        @(negedge clk);
        #1;
        do_reset();

        // single-channel transfers
        for (int v = 0; v < 5; v++) begin
            launch_ch(vecs[v].ch, vecs[v].src, vecs[v].dst, vecs[v].nb, vecs[v].stride,
                      vecs[v].nt, 1'b1, vecs[v].id);
            got = '0;
            for (int b = 0; b < vecs[v].bursts; b++) begin
                s = vecs[v].src + 64'(b) * vecs[v].stride;
                d = vecs[v].dst + 64'(b) * vecs[v].stride;
                take_burst(vecs[v].ch, s, d, vecs[v].nb, got);
            end
            chk("vec_last_src", got, vecs[v].last_src);
            chk("vec_busy_after", busy[vecs[v].ch], 0);
            chk("vec_done_id", done_id[vecs[v].ch], vecs[v].id);
        end

        // three channels launched together, round-robin grant order
        do_reset();
        for (int c = 0; c < 3; c++) set_cfg(c, 64'(c) << 16, 64'h5_0000 + (64'(c) << 16), 64'h10, 64'h100, 32'd2);
        launch = 4'b0111;
        #1;
        chk("multi_ack", ack, 4'b0111);
        chk("multi_next_id2", next_id[2], 1);
        @(negedge clk);
        launch = '0;
        #1;
        for (int g = 0; g < 6; g++) begin
            s = (64'(exp_ch[g]) << 16) + 64'(g / 3) * 64'h100;
            take_burst(exp_ch[g], s, s + 64'h5_0000, 64'h10, got);
        end
        for (int c = 0; c < 3; c++) chk("multi_done_id", done_id[c], 1);

        // rejected launches, stalled backend, n_trans=0
        launch_ch(3, 64'h7000, 64'h7100, 64'h0, 64'h0, 32'd1, 1'b0, 32'd0);
        chk("zero_len_no_valid", valid, 0);
        chk("zero_len_not_busy", busy[3], 0);
        launch_ch(0, 64'hA000, 64'hB000, 64'h80, 64'h40, 32'd0, 1'b1, 32'd2);
        held_src = 64'hA000;
        for (int i = 0; i < 5; i++) begin
            chk("hold_valid", valid, 1);
            chk("hold_chan", bchan, 0);
            chk("hold_src", breq.src_addr, held_src);
            if (i == 1) begin
                set_cfg(3, 64'hE000, 64'hF000, 64'h8, 64'h0, 32'd1);
                launch = 4'b1001;
                #1;
                chk("busy_launch_ack", ack[0], 0);
                chk("busy_launch_id", next_id[0], 0);
                chk("idle_launch_ack", ack[3], 1);
            end
            @(negedge clk);
            launch = '0;
            #1;
        end
        take_burst(0, 64'hA000, 64'hB000, 64'h80, got);
        chk("ntrans0_one_burst_busy", busy[0], 0);
        chk("ntrans0_done_id", done_id[0], 2);
        take_burst(3, 64'hE000, 64'hF000, 64'h8, got);
        chk("ch3_done_id", done_id[3], 1);

        // reset while a burst is in flight
        launch_ch(1, 64'hC000, 64'hC800, 64'h4, 64'h10, 32'd3, 1'b1, 32'd2);
        wait_valid(ok);
        ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
        #1;
        chk("inflight_busy", busy[1], 1);
        do_reset();
        tcomp = 1'b1;
        @(negedge clk);
        tcomp = 1'b0;
        #1;
        chk("post_rst_busy", busy, 0);
        chk("post_rst_valid", valid, 0);
        chk("post_rst_done", done_id[1], 0);
        launch_ch(1, 64'h20, 64'h30, 64'h4, 64'h0, 32'd1, 1'b1, 32'd1);
        take_burst(1, 64'h20, 64'h30, 64'h4, got);
        chk("post_rst_done_after", done_id[1], 1);

`ifdef IDMA_MCHAN_ABORT_EN
        launch_ch(2, 64'hD000, 64'hD100, 64'h8, 64'h10, 32'd5, 1'b1, 32'd1);
        wait_valid(ok);
        ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
        abort[2] = 1'b1;
        @(negedge clk);
        abort = '0;
        #1;
        chk("abort_still_busy", busy[2], 1);
        tcomp = 1'b1;
        @(negedge clk);
        tcomp = 1'b0;
        #1;
        chk("abort_idle", busy[2], 0);
        chk("abort_done_id", done_id[2], 1);
        chk("abort_no_valid", valid, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
